fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of a synchronous FIFO between `N_REQ` producers. Each producer offers a word with a `req` level, and the arbiter grants at most one of them per cycle. It drives the FIFO `write_enable`/`data_i` pair directly and never issues a write while the FIFO reports `full`. An optional burst-lock mode lets a winner keep the port for up to `BURST_LEN` consecutive beats.

## Interface
- `N_REQ`, 4: number of producers, 2..16.
- `M`, 5: data MSB index; word width is `M+1`, matching the FIFO.
- `BURST_LEN`, 4: maximum consecutive beats per grant in burst-lock mode, 1..255.
- `clk` input 1: single clock, rising edge.
- `srst` input 1: synchronous, active-high reset.
- `req` input `N_REQ`: per-producer request level; must be held until granted.
- `data_in` input `N_REQ*(M+1)`: packed words; producer i occupies bits `[i*(M+1) +: M+1]`.
- `gnt` output `N_REQ`: one-hot or zero; bit i high means producer i's word is written this cycle.
- `fifo_full` input 1: FIFO `full` flag.
- `fifo_write_enable` output 1: to FIFO `write_enable`.
- `fifo_data` output `M+1`: to FIFO `data_i`.
- `grant_id` output `$clog2(N_REQ)`: index of the last producer granted, registered.
- `locked` output 1: burst-lock currently held; always 0 when the burst feature is compiled out.

## Operation
- Priority pointer `ptr`:
  - Search order is `ptr`, `ptr+1`, …, wrapping modulo `N_REQ`.
  - The winner is the first index with `req` high.
- Grant is combinational in the cycle:
  - `gnt[w]=1` only if `fifo_full==0`.
  - `fifo_write_enable = |gnt`.
  - `fifo_data` = word of the granted producer; all zeros when there is no grant.
- Handshake:
  - A beat transfers at a rising edge where `req[i] && gnt[i]`.
  - A producer may change its data after each accepted beat.
  - Dropping `req` without a grant is legal and loses nothing.
- Pointer update, only on an accepted beat with no lock held: `ptr <= w+1` (wraps to 0 after `N_REQ-1`).
- `grant_id <= w` on every accepted beat; otherwise it holds its value.
- `fifo_full==1`: `gnt=0`, no write, `ptr` and burst state unchanged.
- `req==0`: `gnt=0`, `fifo_write_enable=0`, state unchanged.
- Reset values:
  - `ptr=0`, `grant_id=0`, `locked=0`, beat counter 0, state `IDLE`.
  - Combinational outputs with `req=0` are `gnt=0`, `fifo_write_enable=0`, `fifo_data=0`.
- `srst` asserted mid-burst: lock is dropped at the next edge, and the pointer returns to 0.

## Timing
- Write latency: zero cycles. The granted word appears on `fifo_data` in the same cycle and is captured by the FIFO at that edge.
- Throughput: one word per cycle while the FIFO is not full.
- No overflow: `fifo_full` is the registered flag, valid for the current edge, so gating on it alone is sufficient.
- A FIFO read does not raise `gnt` in the same cycle. Writes resume in the cycle after `fifo_full` falls.
- `grant_id` updates one cycle after the accepted beat. `locked` updates at the edge of the first beat of a burst.

## Configuration
- `FIFO_ARB_BURST_EN` undefined:
  - Pure round robin; the pointer advances after every beat.
  - `locked` is tied to 0, and `BURST_LEN` is ignored.
- `FIFO_ARB_BURST_EN` defined, two-state FSM:
  - `IDLE`: normal arbitration.
    - On an accepted beat by w with `BURST_LEN>1`: go to `OWN`, owner=w, count=1, `ptr` unchanged.
    - With `BURST_LEN==1`, stay in `IDLE` and advance `ptr`.
  - `OWN`: only the owner may be granted; other requests are masked. On each accepted beat, count++.
    - When count reaches `BURST_LEN`: go to `IDLE`, `ptr<=owner+1`.
    - If the owner drops `req` in a cycle with no beat: go to `IDLE` next edge, `ptr<=owner+1`, no grant that cycle.
    - `fifo_full` in `OWN`: hold the lock, no counting.
  - `locked = (state==OWN)`.

## Test plan
- **Reset, idle inputs:** `srst` for 2 cycles, `req=0` → `gnt=0`, `fifo_write_enable=0`, `grant_id=0`, `locked=0`.
- **Round robin, burst compiled out:** `N_REQ=4`, `req=4'b1111` held for 8 cycles with FIFO depth 8 → grant order 0,1,2,3,0,1,2,3; 8 writes; `fifo_full` rises after the 8th; no further `gnt`.
- **Full back-pressure:** FIFO full, `req=4'b0100` → `gnt=0` until one FIFO read; `gnt=4'b0100` in the cycle after `full` falls; exactly one word written.
- **Wrap-around:** `ptr=3` (after a grant to 2), `req=4'b0101` → producer 0 is granted, then 2; `grant_id` is 0 then 2.
- **Burst lock:** `FIFO_ARB_BURST_EN`, `BURST_LEN=4`, `req=4'b0011` → producer 0 gets 4 consecutive beats with `locked=1`, then producer 1 gets 4.
- **Early release and reset:** `FIFO_ARB_BURST_EN`; owner drops `req` after 2 beats → one idle cycle, then the next requester is granted. Separately, `srst` mid-burst → `locked=0` and `ptr=0` the next cycle.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_write_arbiter: requests, packed words, grants and FIFO write port.
interface fifo_write_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned M     = 5
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*(M+1)-1:0] data_in;
  logic [N_REQ-1:0]       gnt;
  logic                   fifo_full;
  logic                   fifo_write_enable;
  logic [M:0]             fifo_data;
  logic [IDW-1:0]         grant_id;
  logic                   locked;

  modport master (
    output req, data_in, fifo_full,
    input  gnt, fifo_write_enable, fifo_data, grant_id, locked
  );

  modport slave (
    input  req, data_in, fifo_full,
    output gnt, fifo_write_enable, fifo_data, grant_id, locked
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among N_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to BURST_LEN beats.
module fifo_write_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned M         = 5,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                srst,
  fifo_write_arbiter_if.slave bus
);
  localparam int unsigned W   = M + 1;
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_id_q;
  logic [N_REQ-1:0] req_eff_c;
  logic [N_REQ-1:0] gnt_c;
  logic [IDW-1:0]   win_c;
  logic             found_c;
  logic             beat_c;
  logic             locked_c;
  int unsigned      idx_c;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] x);
    return (32'(x) == N_REQ - 1) ? '0 : x + IDW'(1);
  endfunction

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE, OWN} state_e;

  state_e         state_q;
  logic [IDW-1:0] owner_q;
  logic [CW-1:0]  cnt_q;

  // While a burst is held, only the owner may compete.
  always_comb begin
    req_eff_c = bus.req;
    if (state_q == OWN) req_eff_c = bus.req & (N_REQ'(1) << owner_q);
  end

  assign locked_c = (state_q == OWN);

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_q      <= '0;
      grant_id_q <= '0;
      state_q    <= IDLE;
      owner_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (beat_c) grant_id_q <= win_c;
      case (state_q)
        IDLE: begin
          if (beat_c) begin
            if (BURST_LEN > 1) begin
              state_q <= OWN;
              owner_q <= win_c;
              cnt_q   <= CW'(1);
            end else begin
              ptr_q <= ptr_after(win_c);
            end
          end
        end
        OWN: begin
          if (beat_c) begin
            if (cnt_q + CW'(1) == CW'(BURST_LEN)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              ptr_q   <= ptr_after(owner_q);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else if (!bus.req[owner_q]) begin
            // Owner walked away mid-burst: release without granting anyone this cycle.
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= ptr_after(owner_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic unused_burst_len;

  assign req_eff_c        = bus.req;
  assign locked_c         = 1'b0;
  assign unused_burst_len = ^32'(BURST_LEN);

  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_q      <= '0;
      grant_id_q <= '0;
    end else if (beat_c) begin
      ptr_q      <= ptr_after(win_c);
      grant_id_q <= win_c;
    end
  end
`endif

  // First requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_c = (32'(ptr_q) + k) % N_REQ;
      if (!found_c && req_eff_c[idx_c]) begin
        found_c = 1'b1;
        win_c   = IDW'(idx_c);
      end
    end
  end

  assign gnt_c  = (found_c && !bus.fifo_full) ? (N_REQ'(1) << win_c) : '0;
  assign beat_c = |gnt_c;

  assign bus.gnt               = gnt_c;
  assign bus.fifo_write_enable = beat_c;
  assign bus.fifo_data         = beat_c ? bus.data_in[32'(win_c)*W +: W] : '0;
  assign bus.grant_id          = grant_id_q;
  assign bus.locked            = locked_c;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter against a depth-8 FIFO occupancy model.
module tb_fifo_write_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned M     = 5;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        srst;
  logic        rd;
  int unsigned fifo_cnt = 0;
  int unsigned n_wr = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [M:0]  words [N_REQ];

  fifo_write_arbiter_if #(.N_REQ(N_REQ), .M(M)) bus ();

  fifo_write_arbiter #(.N_REQ(N_REQ), .M(M), .BURST_LEN(4)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // FIFO occupancy model; full is a registered flag like the real FIFO.
  always @(posedge clk) begin
    if (srst) begin
      fifo_cnt = 0;
    end else begin
      if (bus.fifo_write_enable) begin
        fifo_cnt = fifo_cnt + 1;
        n_wr     = n_wr + 1;
      end
      if (rd && fifo_cnt > 0) fifo_cnt = fifo_cnt - 1;
    end
    bus.fifo_full <= (fifo_cnt >= DEPTH);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    words[0] = 6'd10;
    words[1] = 6'd21;
    words[2] = 6'd42;
    words[3] = 6'd53;
    srst        = 1'b1;
    rd          = 1'b0;
    bus.req     = '0;
    bus.data_in = {words[3], words[2], words[1], words[0]};

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_we", 32'(bus.fifo_write_enable), 32'd0);
    check("rst_data", 32'(bus.fifo_data), 32'd0);
    check("rst_gid", 32'(bus.grant_id), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);

`ifndef FIFO_ARB_BURST_EN
    // Round robin over all four producers until the FIFO fills.
    @(negedge clk);
    srst    = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_gnt", 32'(bus.gnt), 32'd1 << (k % 4));
      check("rr_data", 32'(bus.fifo_data), 32'(words[k % 4]));
      @(posedge clk);
      #1;
      check("rr_gid", 32'(bus.grant_id), 32'(k % 4));
      @(negedge clk);
    end
    #1;
    check("full_gnt", 32'(bus.gnt), 32'd0);
    check("full_we", 32'(bus.fifo_write_enable), 32'd0);
    check("full_nwr", n_wr, 32'd8);
    @(posedge clk);
    #1;
    check("full_gid_hold", 32'(bus.grant_id), 32'd3);

    // Back-pressure: one read frees exactly one slot.
    @(negedge clk);
    bus.req = 4'b0100;
    #1;
    check("bp_gnt_full", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    rd = 1'b1;
    #1;
    check("bp_gnt_rd", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    rd = 1'b0;
    #1;
    check("bp_gnt", 32'(bus.gnt), 32'b0100);
    check("bp_we", 32'(bus.fifo_write_enable), 32'd1);
    check("bp_data", 32'(bus.fifo_data), 32'(words[2]));
    @(posedge clk);
    #1;
    check("bp_gid", 32'(bus.grant_id), 32'd2);
    @(negedge clk);
    #1;
    check("bp_gnt_refull", 32'(bus.gnt), 32'd0);
    @(posedge clk);
    #1;
    check("bp_nwr", n_wr, 32'd9);

    // Wrap-around from ptr=3 with producers 0 and 2 requesting.
    @(negedge clk);
    bus.req = '0;
    rd      = 1'b1;
    repeat (3) @(negedge clk);
    rd      = 1'b0;
    bus.req = 4'b0101;
    #1;
    check("wrap_gnt0", 32'(bus.gnt), 32'b0001);
    check("wrap_data0", 32'(bus.fifo_data), 32'(words[0]));
    @(posedge clk);
    #1;
    check("wrap_gid0", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    #1;
    check("wrap_gnt2", 32'(bus.gnt), 32'b0100);
    check("wrap_data2", 32'(bus.fifo_data), 32'(words[2]));
    @(posedge clk);
    #1;
    check("wrap_gid2", 32'(bus.grant_id), 32'd2);
    @(negedge clk);
    bus.req = '0;
    #1;
    check("idle_we", 32'(bus.fifo_write_enable), 32'd0);
    check("idle_data", 32'(bus.fifo_data), 32'd0);
    check("wrap_nwr", n_wr, 32'd11);
    check("idle_locked", 32'(bus.locked), 32'd0);
`else
    // Burst lock: producer 0 takes four beats, then producer 1.
    @(negedge clk);
    srst    = 1'b0;
    bus.req = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("burst_gnt", 32'(bus.gnt), (k < 4) ? 32'b0001 : 32'b0010);
      @(posedge clk);
      #1;
      check("burst_locked", 32'(bus.locked), ((k % 4) != 3) ? 32'd1 : 32'd0);
      check("burst_gid", 32'(bus.grant_id), (k < 4) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    #1;
    check("burst_full_gnt", 32'(bus.gnt), 32'd0);
    check("burst_nwr", n_wr, 32'd8);

    // Early release after two beats by the owner.
    srst    = 1'b1;
    bus.req = '0;
    @(negedge clk);
    srst    = 1'b0;
    bus.req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("early_gnt", 32'(bus.gnt), 32'b0001);
      @(posedge clk);
      #1;
      check("early_locked", 32'(bus.locked), 32'd1);
      @(negedge clk);
    end
    bus.req = 4'b0010;
    #1;
    check("early_masked", 32'(bus.gnt), 32'd0);
    @(posedge clk);
    #1;
    check("early_unlock", 32'(bus.locked), 32'd0);
    @(negedge clk);
    #1;
    check("early_next", 32'(bus.gnt), 32'b0010);
    @(posedge clk);
    #1;
    check("early_relock", 32'(bus.locked), 32'd1);

    // Reset in the middle of producer 1's burst.
    @(negedge clk);
    srst    = 1'b1;
    bus.req = 4'b0011;
    @(posedge clk);
    #1;
    check("srst_locked", 32'(bus.locked), 32'd0);
    @(negedge clk);
    srst = 1'b0;
    #1;
    check("srst_ptr0", 32'(bus.gnt), 32'b0001);
    check("srst_gid", 32'(bus.grant_id), 32'd0);
    @(negedge clk);
    bus.req = '0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
